// File: rtl/g31_sha256_pkg.sv
// Shared constants, register addresses, FSM encodings and SHA-256 bit functions
// used by the g31 Avalon-MM SHA-256 core.
package g31_sha256_pkg;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [4:0] ADDR_CTRL   = 5'h10;
  localparam logic [4:0] ADDR_STATUS = 5'h11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_FINAL = 2'd3;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/g31_sha256_round.sv
// Combinational SHA-256 compression round. Index 0 of the working-variable
// vector is 'a', index 7 is 'h'.
module g31_sha256_round
  import g31_sha256_pkg::*;
(
  input  logic [7:0][31:0] i_abcdefgh,
  input  logic [31:0]      i_w,
  input  logic [31:0]      i_k,
  output logic [7:0][31:0] o_abcdefgh
);

  logic [31:0] w_t1;
  logic [31:0] w_t2;

  assign w_t1 = i_abcdefgh[7] + big_sigma1(i_abcdefgh[4])
              + ch(i_abcdefgh[4], i_abcdefgh[5], i_abcdefgh[6]) + i_k + i_w;
  assign w_t2 = big_sigma0(i_abcdefgh[0]) + maj(i_abcdefgh[0], i_abcdefgh[1], i_abcdefgh[2]);

  always_comb begin
    o_abcdefgh[0] = w_t1 + w_t2;
    o_abcdefgh[1] = i_abcdefgh[0];
    o_abcdefgh[2] = i_abcdefgh[1];
    o_abcdefgh[3] = i_abcdefgh[2];
    o_abcdefgh[4] = i_abcdefgh[3] + w_t1;
    o_abcdefgh[5] = i_abcdefgh[4];
    o_abcdefgh[6] = i_abcdefgh[5];
    o_abcdefgh[7] = i_abcdefgh[6];
  end

endmodule

// File: rtl/g31_sha256_avs_core.sv
// Avalon-MM slave SHA-256 block engine: register file, message schedule,
// round counter and control FSM; one compression round per clock.
module g31_sha256_avs_core
  import g31_sha256_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter bit          IRQ_EN = 1'b1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_chipselect,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq,
  output logic              busy
);

  logic [31:0]      r_msg   [16];
  logic [31:0]      r_h     [8];
  logic [31:0]      r_sched [16];
  logic [7:0][31:0] r_wv;
  logic [5:0]       r_t;
  logic [1:0]       r_state;
  logic             r_done;
  logic             r_ie;
  logic             r_irq;
  logic [31:0]      r_rdata;

  logic [4:0]       w_addr;
  logic             w_hi_ok;
  logic             w_wr;
  logic             w_rd;
  logic             w_busy;
  logic             w_start;
  logic [31:0]      w_rdata;
  logic [31:0]      w_w_new;
  logic [7:0][31:0] w_wv_next;

  assign w_addr  = avs_address[4:0];
  assign w_hi_ok = (avs_address >> 5) == '0;
  assign w_wr    = avs_chipselect & avs_write & w_hi_ok;
  // A simultaneous write takes priority, so the read register holds.
  assign w_rd    = avs_chipselect & avs_read & ~avs_write & w_hi_ok;
  assign w_busy  = (r_state != ST_IDLE);
  assign w_start = w_wr & (w_addr == ADDR_CTRL) & avs_writedata[0] & ~w_busy;

  assign w_w_new = small_sigma1(r_sched[14]) + r_sched[9]
                 + small_sigma0(r_sched[1]) + r_sched[0];

  g31_sha256_round u_round (
    .i_abcdefgh (r_wv),
    .i_w        (r_sched[0]),
    .i_k        (K[r_t]),
    .o_abcdefgh (w_wv_next)
  );

  always_comb begin
    w_rdata = '0;
    if (!w_addr[4]) begin
      w_rdata = r_msg[w_addr[3:0]];
    end else if (w_addr == ADDR_CTRL) begin
      w_rdata = {29'b0, r_ie, 2'b0};
    end else if (w_addr == ADDR_STATUS) begin
      w_rdata = {30'b0, r_done, w_busy};
    end else if (w_addr[4:3] == 2'b11) begin
      w_rdata = r_h[w_addr[2:0]];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 16; i++) begin
        r_msg[i]   <= '0;
        r_sched[i] <= '0;
      end
      for (int i = 0; i < 8; i++) begin
        r_h[i] <= IV[i];
      end
      r_wv    <= '0;
      r_t     <= '0;
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_ie    <= 1'b0;
      r_irq   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_irq <= IRQ_EN & r_ie & r_done;
      if (w_rd) begin
        r_rdata <= w_rdata;
      end
      if (w_wr && !w_addr[4] && !w_busy) begin
        r_msg[w_addr[3:0]] <= avs_writedata;
      end
      if (w_wr && w_addr == ADDR_CTRL) begin
        r_ie <= avs_writedata[2];
      end
      if ((w_wr && w_addr == ADDR_STATUS && avs_writedata[1]) || w_start) begin
        r_done <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            if (avs_writedata[1]) begin
              for (int i = 0; i < 8; i++) r_h[i] <= IV[i];
            end
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          for (int i = 0; i < 8; i++) r_wv[i] <= r_h[i];
          for (int i = 0; i < 16; i++) r_sched[i] <= r_msg[i];
          r_t     <= '0;
          r_state <= ST_ROUND;
        end
        ST_ROUND: begin
          r_wv <= w_wv_next;
          for (int i = 0; i < 15; i++) r_sched[i] <= r_sched[i+1];
          r_sched[15] <= w_w_new;
          r_t         <= r_t + 6'd1;
          if (r_t == 6'd63) begin
            r_state <= ST_FINAL;
          end
        end
        default: begin
          for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_wv[i];
          // Completion wins over a concurrent DONE-clear so no result is lost.
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign avs_readdata = r_rdata;
  assign irq          = r_irq;
  assign busy         = w_busy;

endmodule

// File: tb/tb_g31_sha256_avs_core.sv
// Directed bench for g31_sha256_avs_core with a transaction-level register and
// SHA-256 model checked against the DUT outputs every cycle.
module tb_g31_sha256_avs_core;
  import g31_sha256_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  addr = '0;
  logic        cs = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  g31_sha256_avs_core #(.ADDR_W(5), .IRQ_EN(1'b1)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .avs_address    (addr),
    .avs_chipselect (cs),
    .avs_read       (rd),
    .avs_write      (wr),
    .avs_writedata  (wdata),
    .avs_readdata   (rdata),
    .irq            (irq),
    .busy           (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_cnt;
  logic [31:0] m_h    [8];
  logic [31:0] m_msg  [16];
  logic [31:0] m_snap [16];
  logic        m_ie, m_done, m_irq;
  logic [31:0] m_rdata;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic model_compress();
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    for (int t = 0; t < 16; t++) w[t] = m_snap[t];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = m_h[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) m_h[i] = m_h[i] + v[i];
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a < 5'h10) return m_msg[a[3:0]];
    if (a == 5'h10) return {29'b0, m_ie, 2'b0};
    if (a == 5'h11) return {30'b0, m_done, (m_cnt > 0)};
    if (a >= 5'h18) return m_h[a[2:0]];
    return 32'h0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic        pre_busy;
    logic        fin;
    logic [31:0] rv;
    if (!rst_n) begin
      m_cnt = 0;
      for (int i = 0; i < 8; i++) m_h[i] = IV[i];
      for (int i = 0; i < 16; i++) m_msg[i] = '0;
      m_ie = 1'b0; m_done = 1'b0; m_irq = 1'b0; m_rdata = '0;
    end else begin
      pre_busy = (m_cnt > 0);
      fin      = 1'b0;
      rv       = model_read(addr);
      m_irq    = m_ie & m_done;
      if (pre_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          model_compress();
          fin = 1'b1;
        end
      end
      if (cs && wr) begin
        if (addr < 5'h10 && !pre_busy) m_msg[addr[3:0]] = wdata;
        if (addr == 5'h10) begin
          m_ie = wdata[2];
          if (wdata[0] && !pre_busy) begin
            if (wdata[1]) for (int i = 0; i < 8; i++) m_h[i] = IV[i];
            for (int i = 0; i < 16; i++) m_snap[i] = m_msg[i];
            m_done = 1'b0;
            m_cnt  = 66;
          end
        end
        if (addr == 5'h11 && wdata[1]) m_done = 1'b0;
      end else if (cs && rd) begin
        m_rdata = rv;
      end
      if (fin) m_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("cyc_busy", {31'b0, busy}, {31'b0, (m_cnt > 0)});
      check("cyc_irq", {31'b0, irq}, {31'b0, m_irq});
      check("cyc_rdata", rdata, m_rdata);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] blk [16];

  task automatic wr32(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd32(input logic [4:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    d = rdata;
  endtask

  task automatic load_blk();
    for (int i = 0; i < 16; i++) wr32(5'(i), blk[i]);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0] = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic wait_idle(input string name, output int cycles);
    cycles = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
      cycles++;
    end
    check({name, "_timeout"}, {31'b0, busy}, 32'h0);
  endtask

  logic [31:0] d;
  int          c;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Reset values
    rd32(5'h18, d); check("rst_h0", d, 32'h6a09e667);
    rd32(5'h1f, d); check("rst_h7", d, 32'h5be0cd19);
    rd32(5'h11, d); check("rst_status", d, 32'h0);
    rd32(5'h14, d); check("unmapped", d, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // "abc"
    set_abc(); load_blk();
    wr32(5'h10, 32'h3);
    wait_idle("abc", c);
    check("abc_busy_cycles", c, 66);
    rd32(5'h11, d); check("abc_status", d, 32'h2);
    rd32(5'h18, d); check("abc_h0", d, 32'hba7816bf);
    rd32(5'h1f, d); check("abc_h7", d, 32'hf20015ad);
    check("model_abc_h0", m_h[0], 32'hba7816bf);
    check("abc_noirq", {31'b0, irq}, 32'h0);

    // Empty message with IE
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0] = 32'h80000000;
    load_blk();
    wr32(5'h10, 32'h7);
    wait_idle("empty", c);
    check("empty_irq_n67", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("empty_irq_n68", {31'b0, irq}, 32'h1);
    rd32(5'h18, d); check("empty_h0", d, 32'he3b0c442);
    rd32(5'h1f, d); check("empty_h7", d, 32'h7852b855);
    rd32(5'h10, d); check("ctrl_ie", d, 32'h4);
    wr32(5'h11, 32'h2);
    @(posedge clk); #1;
    check("irq_cleared", {31'b0, irq}, 32'h0);
    wr32(5'h10, 32'h0);

    // NIST two-block message
    blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    load_blk();
    wr32(5'h10, 32'h3);
    wait_idle("nist1", c);
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[15] = 32'h000001c0;
    load_blk();
    wr32(5'h10, 32'h1);
    wait_idle("nist2", c);
    rd32(5'h18, d); check("nist_h0", d, 32'h248d6a61);
    rd32(5'h1f, d); check("nist_h7", d, 32'h19db06c1);

    // Writes during compression are ignored
    set_abc(); load_blk();
    wr32(5'h10, 32'h3);
    repeat (20) @(negedge clk);
    wr32(5'h03, 32'hffffffff);
    wr32(5'h10, 32'h3);
    wait_idle("prot", c);
    rd32(5'h03, d); check("prot_msg3", d, 32'h0);
    rd32(5'h18, d); check("prot_h0", d, 32'hba7816bf);
    c = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy) c++;
    end
    check("prot_single_run", c, 0);

    // Reset in the middle of the rounds
    wr32(5'h10, 32'h3);
    repeat (32) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd32(5'h18, d); check("midrst_h0", d, 32'h6a09e667);
    rd32(5'h1f, d); check("midrst_h7", d, 32'h5be0cd19);
    rd32(5'h00, d); check("midrst_msg0", d, 32'h0);
    set_abc(); load_blk();
    wr32(5'h10, 32'h1);
    wait_idle("post", c);
    check("post_busy_cycles", c, 66);
    rd32(5'h18, d); check("post_h0", d, 32'hba7816bf);
    rd32(5'h1f, d); check("post_h7", d, 32'hf20015ad);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
